// File: rtl/ppu_pixel_fifo_pkg.sv
// Shared types and helpers for the PPU pixel FIFO: entry attributes, default
// geometry and the sprite-over-background overlay rule.
package ppu_pixel_fifo_pkg;

  localparam int PIXEL_BITS_DEF   = 2;
  localparam int TILE_SIZE        = 8;
  localparam int PIXEL_FIFO_DEPTH = 16;

  typedef struct packed {
    logic is_sprite;
    logic pal_sel;
    logic prio;
  } pix_attr_t;

  localparam pix_attr_t ATTR_BG = '{is_sprite: 1'b0, pal_sel: 1'b0, prio: 1'b0};

  // A slot already owned by a sprite keeps it: earlier OAM entries win.
  function automatic logic sprite_replaces(input logic bg_is_sprite,
                                           input logic bg_idx_zero,
                                           input logic spr_idx_nonzero,
                                           input logic spr_prio);
    return !bg_is_sprite && spr_idx_nonzero && (!spr_prio || bg_idx_zero);
  endfunction

endpackage

// File: rtl/ppu_pixel_fifo_if.sv
// Fetcher/sprite/LCD-side bus of the pixel FIFO. master = fetcher + line writer,
// slave = the FIFO itself.
interface ppu_pixel_fifo_if #(
  parameter int PIXEL_BITS = 2,
  parameter int PUSH_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int PAL_W = PIXEL_BITS << PIXEL_BITS;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                             flush_i;
  logic                             push_valid_i;
  logic                             push_ready_o;
  logic [PUSH_WIDTH*PIXEL_BITS-1:0] push_row_i;
  logic                             push_hflip_i;
  logic                             merge_valid_i;
  logic                             merge_ready_o;
  logic [PUSH_WIDTH*PIXEL_BITS-1:0] merge_row_i;
  logic                             merge_hflip_i;
  logic                             merge_pal_i;
  logic                             merge_prio_i;
  logic                             pop_en_i;
  logic [PAL_W-1:0]                 bgp_i;
  logic [PAL_W-1:0]                 obp0_i;
  logic [PAL_W-1:0]                 obp1_i;
  logic                             pix_valid_o;
  logic [PIXEL_BITS-1:0]            pix_o;
  logic [CW-1:0]                    count_o;

  modport master (
    output flush_i, push_valid_i, push_row_i, push_hflip_i,
           merge_valid_i, merge_row_i, merge_hflip_i, merge_pal_i, merge_prio_i,
           pop_en_i, bgp_i, obp0_i, obp1_i,
    input  push_ready_o, merge_ready_o, pix_valid_o, pix_o, count_o
  );

  modport slave (
    input  flush_i, push_valid_i, push_row_i, push_hflip_i,
           merge_valid_i, merge_row_i, merge_hflip_i, merge_pal_i, merge_prio_i,
           pop_en_i, bgp_i, obp0_i, obp1_i,
    output push_ready_o, merge_ready_o, pix_valid_o, pix_o, count_o
  );

endinterface

// File: rtl/ppu_sprite_merge.sv
// One FIFO slot's sprite overlay: decides whether the incoming sprite pixel
// takes the slot and produces the resulting entry.
module ppu_sprite_merge
  import ppu_pixel_fifo_pkg::*;
#(
  parameter int PIXEL_BITS = PIXEL_BITS_DEF
) (
  input  logic [PIXEL_BITS-1:0] i_bg_idx,
  input  pix_attr_t             i_bg_attr,
  input  logic [PIXEL_BITS-1:0] i_spr_idx,
  input  logic                  i_spr_pal,
  input  logic                  i_spr_prio,
  output logic                  o_replace,
  output logic [PIXEL_BITS-1:0] o_idx,
  output pix_attr_t             o_attr
);

  // Overlay decision and resulting slot contents
  always_comb begin
    o_replace = sprite_replaces(i_bg_attr.is_sprite,
                                (i_bg_idx == {PIXEL_BITS{1'b0}}),
                                (i_spr_idx != {PIXEL_BITS{1'b0}}),
                                i_spr_prio);
    if (o_replace) begin
      o_idx  = i_spr_idx;
      o_attr = '{is_sprite: 1'b1, pal_sel: i_spr_pal, prio: i_spr_prio};
    end else begin
      o_idx  = i_bg_idx;
      o_attr = i_bg_attr;
    end
  end

endmodule

// File: rtl/ppu_pixel_fifo.sv
// PPU pixel FIFO: row push from the tile fetcher, sprite overlay at the head,
// palette lookup and one registered shade per accepted pixel strobe.
module ppu_pixel_fifo
  import ppu_pixel_fifo_pkg::*;
#(
  parameter int PIXEL_BITS = PIXEL_BITS_DEF,
  parameter int PUSH_WIDTH = TILE_SIZE,
  parameter int DEPTH      = PIXEL_FIFO_DEPTH
) (
  input logic             clk,
  input logic             rst_n,
  ppu_pixel_fifo_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int PAL_W = PIXEL_BITS << PIXEL_BITS;

  typedef logic [PIXEL_BITS-1:0] idx_t;

  idx_t             r_idx  [DEPTH];
  pix_attr_t        r_attr [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_pix_valid;
  idx_t             r_pix;

  logic             w_push_ready;
  logic             w_merge_ready;
  logic             w_push_fire;
  logic             w_merge_fire;
  logic             w_pop_fire;
  idx_t             w_push_px [PUSH_WIDTH];
  idx_t             w_spr_px  [PUSH_WIDTH];
  logic             w_repl    [PUSH_WIDTH];
  idx_t             w_mrg_idx [PUSH_WIDTH];
  pix_attr_t        w_mrg_attr[PUSH_WIDTH];
  idx_t             w_head_idx;
  pix_attr_t        w_head_attr;
  logic [PAL_W-1:0] w_pal;
  idx_t             w_shade;
  logic [CW-1:0]    w_count_nxt;

  // Handshakes: push credit ignores a same-cycle pop; merge blocks pop
  always_comb begin
    w_push_ready  = (CW'(DEPTH) - r_count) >= CW'(PUSH_WIDTH);
    w_merge_ready = (r_count >= CW'(PUSH_WIDTH)) && !bus.flush_i;
    w_push_fire   = bus.push_valid_i && w_push_ready && !bus.flush_i;
    w_merge_fire  = bus.merge_valid_i && w_merge_ready;
    w_pop_fire    = bus.pop_en_i && (r_count != {CW{1'b0}}) && !w_merge_fire && !bus.flush_i;
  end

  // Row unpacking: pixel 0 sits in the MSBs unless the row is flipped
  always_comb begin
    for (int k = 0; k < PUSH_WIDTH; k++) begin
      if (bus.push_hflip_i) begin
        w_push_px[k] = bus.push_row_i[k*PIXEL_BITS +: PIXEL_BITS];
      end else begin
        w_push_px[k] = bus.push_row_i[(PUSH_WIDTH-1-k)*PIXEL_BITS +: PIXEL_BITS];
      end
      if (bus.merge_hflip_i) begin
        w_spr_px[k] = bus.merge_row_i[k*PIXEL_BITS +: PIXEL_BITS];
      end else begin
        w_spr_px[k] = bus.merge_row_i[(PUSH_WIDTH-1-k)*PIXEL_BITS +: PIXEL_BITS];
      end
    end
  end

  for (genvar g = 0; g < PUSH_WIDTH; g++) begin : g_merge
    logic [AW-1:0] w_slot;
    assign w_slot = r_rd_ptr + AW'(g);
    ppu_sprite_merge #(.PIXEL_BITS(PIXEL_BITS)) u_merge (
      .i_bg_idx  (r_idx[w_slot]),
      .i_bg_attr (r_attr[w_slot]),
      .i_spr_idx (w_spr_px[g]),
      .i_spr_pal (bus.merge_pal_i),
      .i_spr_prio(bus.merge_prio_i),
      .o_replace (w_repl[g]),
      .o_idx     (w_mrg_idx[g]),
      .o_attr    (w_mrg_attr[g])
    );
  end

  // Head palette lookup, using the palette registers as they stand this cycle
  always_comb begin
    w_head_idx  = r_idx[r_rd_ptr];
    w_head_attr = r_attr[r_rd_ptr];
    if (!w_head_attr.is_sprite) begin
      w_pal = bus.bgp_i;
    end else if (w_head_attr.pal_sel) begin
      w_pal = bus.obp1_i;
    end else begin
      w_pal = bus.obp0_i;
    end
    w_shade     = w_pal[int'(w_head_idx)*PIXEL_BITS +: PIXEL_BITS];
    w_count_nxt = r_count;
    if (w_push_fire) begin
      w_count_nxt = w_count_nxt + CW'(PUSH_WIDTH);
    end else begin
      w_count_nxt = w_count_nxt;
    end
    if (w_pop_fire) begin
      w_count_nxt = w_count_nxt - CW'(1);
    end else begin
      w_count_nxt = w_count_nxt;
    end
  end

  // Entry storage: push fills free slots, merge rewrites head slots; never overlapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_idx[k]  <= {PIXEL_BITS{1'b0}};
        r_attr[k] <= ATTR_BG;
      end
    end else begin
      if (w_push_fire) begin
        for (int k = 0; k < PUSH_WIDTH; k++) begin
          r_idx[r_wr_ptr + AW'(k)]  <= w_push_px[k];
          r_attr[r_wr_ptr + AW'(k)] <= ATTR_BG;
        end
      end
      if (w_merge_fire) begin
        for (int k = 0; k < PUSH_WIDTH; k++) begin
          if (w_repl[k]) begin
            r_idx[r_rd_ptr + AW'(k)]  <= w_mrg_idx[k];
            r_attr[r_rd_ptr + AW'(k)] <= w_mrg_attr[k];
          end
        end
      end
    end
  end

  // Pointers, occupancy and the registered pixel output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= {AW{1'b0}};
      r_wr_ptr    <= {AW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_pix_valid <= 1'b0;
      r_pix       <= {PIXEL_BITS{1'b0}};
    end else if (bus.flush_i) begin
      r_rd_ptr    <= {AW{1'b0}};
      r_wr_ptr    <= {AW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_pix_valid <= 1'b0;
    end else begin
      if (w_push_fire) begin
        r_wr_ptr <= r_wr_ptr + AW'(PUSH_WIDTH);
      end
      if (w_pop_fire) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_pix    <= w_shade;
      end
      r_pix_valid <= w_pop_fire;
      r_count     <= w_count_nxt;
    end
  end

  assign bus.push_ready_o  = w_push_ready;
  assign bus.merge_ready_o = w_merge_ready;
  assign bus.pix_valid_o   = r_pix_valid;
  assign bus.pix_o         = r_pix;
  assign bus.count_o       = r_count;

endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Self-checking bench for ppu_pixel_fifo: directed scenarios then random traffic,
// all compared against a queue-based model of the pixel pipeline.
module tb_ppu_pixel_fifo;

  localparam int PB    = 2;
  localparam int PW    = 8;
  localparam int D     = 16;
  localparam int RW    = PW * PB;
  localparam int PAL_W = PB << PB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ppu_pixel_fifo_if #(.PIXEL_BITS(PB), .PUSH_WIDTH(PW), .DEPTH(D)) bus ();
  ppu_pixel_fifo #(.PIXEL_BITS(PB), .PUSH_WIDTH(PW), .DEPTH(D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int idx;
    bit spr;
    bit pal;
    bit prio;
  } ent_t;

  ent_t q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   exp_pix   = 0;
  int   exp_valid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int row_px(input logic [RW-1:0] row, input bit hflip, input int k);
    int pos;
    pos = hflip ? k : (PW - 1 - k);
    return int'((row >> (pos * PB)) & RW'((1 << PB) - 1));
  endfunction

  function automatic int shade(input logic [PAL_W-1:0] pal, input int idx);
    return int'((pal >> (idx * PB)) & PAL_W'((1 << PB) - 1));
  endfunction

  task automatic idle();
    bus.flush_i       = 1'b0;
    bus.push_valid_i  = 1'b0;
    bus.push_row_i    = '0;
    bus.push_hflip_i  = 1'b0;
    bus.merge_valid_i = 1'b0;
    bus.merge_row_i   = '0;
    bus.merge_hflip_i = 1'b0;
    bus.merge_pal_i   = 1'b0;
    bus.merge_prio_i  = 1'b0;
    bus.pop_en_i      = 1'b0;
  endtask

  // One clock: model update from the current inputs, then output comparison.
  task automatic step(input string tag);
    bit   prdy, mrdy, dpush, dmrg, dpop;
    int   cnt, s;
    ent_t e;
    #1;
    cnt  = q.size();
    prdy = (D - cnt) >= PW;
    mrdy = (cnt >= PW) && !bus.flush_i;
    chk({tag, ".push_ready"}, 32'(bus.push_ready_o), 32'(prdy));
    chk({tag, ".merge_ready"}, 32'(bus.merge_ready_o), 32'(mrdy));
    dpush = bus.push_valid_i && prdy && !bus.flush_i;
    dmrg  = bus.merge_valid_i && mrdy;
    dpop  = bus.pop_en_i && (cnt > 0) && !dmrg && !bus.flush_i;
    if (bus.flush_i) begin
      q.delete();
      exp_valid = 0;
    end else begin
      if (dmrg) begin
        for (int k = 0; k < PW; k++) begin
          s = row_px(bus.merge_row_i, bus.merge_hflip_i, k);
          if (!q[k].spr && s != 0 && (!bus.merge_prio_i || q[k].idx == 0)) begin
            q[k] = '{idx: s, spr: 1'b1, pal: bus.merge_pal_i, prio: bus.merge_prio_i};
          end
        end
      end
      if (dpop) begin
        e = q.pop_front();
        if (!e.spr) exp_pix = shade(bus.bgp_i, e.idx);
        else if (e.pal) exp_pix = shade(bus.obp1_i, e.idx);
        else exp_pix = shade(bus.obp0_i, e.idx);
      end
      exp_valid = dpop ? 1 : 0;
      if (dpush) begin
        for (int k = 0; k < PW; k++) begin
          q.push_back('{idx: row_px(bus.push_row_i, bus.push_hflip_i, k), spr: 1'b0, pal: 1'b0, prio: 1'b0});
        end
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".pix_valid"}, 32'(bus.pix_valid_o), 32'(exp_valid));
    chk({tag, ".pix"}, 32'(bus.pix_o), 32'(exp_pix));
    chk({tag, ".count"}, 32'(bus.count_o), 32'(q.size()));
  endtask

  task automatic push_row(input string tag, input logic [RW-1:0] row, input bit hflip);
    bus.push_valid_i = 1'b1;
    bus.push_row_i   = row;
    bus.push_hflip_i = hflip;
    step(tag);
    idle();
  endtask

  task automatic merge_row(input string tag, input logic [RW-1:0] row, input bit pal,
                           input bit prio, input bit with_pop);
    bus.merge_valid_i = 1'b1;
    bus.merge_row_i   = row;
    bus.merge_pal_i   = pal;
    bus.merge_prio_i  = prio;
    bus.pop_en_i      = with_pop;
    step(tag);
    idle();
  endtask

  task automatic pops(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      bus.pop_en_i = 1'b1;
      step(tag);
    end
    idle();
  endtask

  initial begin
    idle();
    bus.bgp_i  = 8'hE4;
    bus.obp0_i = 8'hE4;
    bus.obp1_i = 8'h00;
    #2;
    chk("reset.pix_valid", 32'(bus.pix_valid_o), 32'd0);
    chk("reset.pix", 32'(bus.pix_o), 32'd0);
    chk("reset.count", 32'(bus.count_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: plain BG row, identity palette
    push_row("t1.push", 16'h1B1B, 1'b0);
    pops("t1.pop", 8);
    chk("t1.last_pix", 32'(bus.pix_o), 32'd3);
    pops("t1.empty_pop", 1);

    // 2: flipped row, reversed palette
    bus.bgp_i = 8'h1B;
    push_row("t2.push", 16'h1B1B, 1'b1);
    pops("t2.pop", 8);

    // 3: sprite over transparent BG using OBP1; pop stalled by the merge
    bus.bgp_i  = 8'hE4;
    bus.obp1_i = 8'h00;
    push_row("t3.push", 16'h0000, 1'b0);
    merge_row("t3.merge", 16'hFFFF, 1'b1, 1'b0, 1'b1);
    pops("t3.pop", 8);

    // 4: BG-priority sprite loses to idx 1, wins over idx 0
    bus.obp0_i = 8'h1B;
    push_row("t4a.push", 16'h5555, 1'b0);
    merge_row("t4a.merge", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    pops("t4a.pop", 8);
    push_row("t4b.push", 16'h0000, 1'b0);
    merge_row("t4b.merge", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    pops("t4b.pop", 8);

    // 5: second sprite only fills slots the first left transparent
    bus.obp1_i = 8'hE4;
    push_row("t5.push", 16'h0000, 1'b0);
    merge_row("t5.merge1", 16'hC3C3, 1'b0, 1'b0, 1'b0);
    merge_row("t5.merge2", 16'h5555, 1'b1, 1'b0, 1'b0);
    pops("t5.pop", 8);

    // 6: full, push+pop with 9 and 8, flush, async reset mid-pop
    push_row("t6.push1", 16'h1234, 1'b0);
    push_row("t6.push2", 16'hABCD, 1'b0);
    push_row("t6.push_full", 16'hFFFF, 1'b0);
    pops("t6.drain", 7);
    bus.push_valid_i = 1'b1; bus.push_row_i = 16'h9999; bus.pop_en_i = 1'b1;
    step("t6.pushpop9");
    step("t6.pushpop8");
    bus.flush_i = 1'b1; bus.merge_valid_i = 1'b1;
    step("t6.flush");
    idle();
    chk("t6.flush_count", 32'(bus.count_o), 32'd0);
    bus.bgp_i = 8'hFF;
    push_row("t6.push3", 16'h5A5A, 1'b0);
    pops("t6.pop", 1);
    rst_n = 1'b0;
    #1;
    chk("t6.arst_valid", 32'(bus.pix_valid_o), 32'd0);
    chk("t6.arst_pix", 32'(bus.pix_o), 32'd0);
    chk("t6.arst_count", 32'(bus.count_o), 32'd0);
    q.delete();
    exp_pix   = 0;
    exp_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bus.push_valid_i  = $urandom_range(1, 0) == 1;
      bus.push_row_i    = RW'($urandom);
      bus.push_hflip_i  = $urandom_range(1, 0) == 1;
      bus.merge_valid_i = $urandom_range(3, 0) == 0;
      bus.merge_row_i   = RW'($urandom);
      bus.merge_hflip_i = $urandom_range(1, 0) == 1;
      bus.merge_pal_i   = $urandom_range(1, 0) == 1;
      bus.merge_prio_i  = $urandom_range(1, 0) == 1;
      bus.pop_en_i      = $urandom_range(2, 0) != 0;
      bus.flush_i       = $urandom_range(49, 0) == 0;
      if ($urandom_range(15, 0) == 0) begin
        bus.bgp_i  = PAL_W'($urandom);
        bus.obp0_i = PAL_W'($urandom);
        bus.obp1_i = PAL_W'($urandom);
      end
      step("rnd");
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
